// File: rtl/kbd_pkg.sv
// Shared scancode constants, FSM state encoding and decode helpers for the
// keyboard event sequencer.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2
    } kbd_state_e;

    // A prefix byte only modifies the following scancode, it never forms an event.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK);
    endfunction

    function automatic logic is_shift(input logic [7:0] b);
        return (b == SC_LSHIFT) || (b == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// FIFO-side and consumer-side signals of the keyboard event sequencer.
interface kbd_event_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       kb_data;
    logic             kb_ready;
    logic             kb_overflow;
    logic             kb_nextdata;
    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic             ev_repeat;
    logic             shift;
    logic             ctrl;
    logic             caps;
    logic [CNT_W-1:0] press_cnt;
    logic             overflow_sticky;

    // Sequencer side.
    modport slave (
        input  kb_data, kb_ready, kb_overflow, ev_ready,
        output kb_nextdata, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
               shift, ctrl, caps, press_cnt, overflow_sticky
    );

    // Environment side (FIFO plus consumer).
    modport master (
        output kb_data, kb_ready, kb_overflow, ev_ready,
        input  kb_nextdata, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
               shift, ctrl, caps, press_cnt, overflow_sticky
    );
endinterface

// File: rtl/kbd_mod_state.sv
// Modifier, caps-lock, held-key and press-count state, updated once per
// decoded (non-prefix) scancode strobe.
module kbd_mod_state
    import kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ev_stb,
    input  logic [7:0]       ev_code,
    input  logic             ev_ext,
    input  logic             ev_break,
    output logic             is_repeat,
    output logic             shift,
    output logic             ctrl,
    output logic             caps,
    output logic [CNT_W-1:0] press_cnt
);
    logic             held_valid_r;
    logic [7:0]       held_code_r;
    logic             held_ext_r;
    logic             shift_r;
    logic             ctrl_r;
    logic             caps_r;
    logic [CNT_W-1:0] press_cnt_r;
    logic             match_s;

    // Compare the incoming event against the currently held key.
    always_comb begin
        match_s   = held_valid_r && (held_code_r == ev_code) && (held_ext_r == ev_ext);
        is_repeat = match_s && !ev_break;
    end

    // Apply one decoded event to the modifier and held-key state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held_valid_r <= 1'b0;
            held_code_r  <= 8'h00;
            held_ext_r   <= 1'b0;
            shift_r      <= 1'b0;
            ctrl_r       <= 1'b0;
            caps_r       <= 1'b0;
            press_cnt_r  <= '0;
        end else if (ev_stb) begin
            // Both shift keys share one bit: any shift release clears it.
            if (is_shift(ev_code)) begin
                shift_r <= !ev_break;
            end
            if (ev_code == SC_CTRL) begin
                ctrl_r <= !ev_break;
            end
            if (!ev_break && !match_s) begin
                held_valid_r <= 1'b1;
                held_code_r  <= ev_code;
                held_ext_r   <= ev_ext;
                press_cnt_r  <= press_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if ((ev_code == SC_CAPS) && !ev_ext) begin
                    caps_r <= !caps_r;
                end
            end else if (ev_break && match_s) begin
                held_valid_r <= 1'b0;
            end
        end
    end

    assign shift     = shift_r;
    assign ctrl      = ctrl_r;
    assign caps      = caps_r;
    assign press_cnt = press_cnt_r;

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event sequencer: pops the PS/2 FIFO, strips E0/F0 prefixes and
// presents one key event at a time on a valid/ready interface.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter bit SUPPRESS_REPEAT = 1'b1,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             clrn,
    kbd_event_ctrl_if.slave  bus
);
    kbd_state_e state_r;
    logic [7:0] byte_r;
    logic       ext_pend_r;
    logic       brk_pend_r;
    logic       ovf_d_r;
    logic       nextdata_r;
    logic       ev_valid_r;
    logic [7:0] ev_code_r;
    logic       ev_ext_r;
    logic       ev_break_r;
    logic       ev_repeat_r;
    logic       ovf_sticky_r;

    logic       ovf_rise_s;
    logic       ev_stb_s;
    logic       is_repeat_s;
    logic       drop_s;

    // Decode strobes: overflow edge, real-scancode strobe, suppressed repeat.
    always_comb begin
        ovf_rise_s = bus.kb_overflow && !ovf_d_r;
        ev_stb_s   = (state_r == DECODE) && !is_prefix(byte_r);
        drop_s     = ev_stb_s && is_repeat_s && (SUPPRESS_REPEAT != 1'b0);
    end

    kbd_mod_state #(
        .CNT_W (CNT_W)
    ) u_mod_state (
        .clk       (clk),
        .clrn      (clrn),
        .ev_stb    (ev_stb_s),
        .ev_code   (byte_r),
        .ev_ext    (ext_pend_r),
        .ev_break  (brk_pend_r),
        .is_repeat (is_repeat_s),
        .shift     (bus.shift),
        .ctrl      (bus.ctrl),
        .caps      (bus.caps),
        .press_cnt (bus.press_cnt)
    );

    // Sequencer FSM with registered FIFO pop strobe and event outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= IDLE;
            byte_r       <= 8'h00;
            ext_pend_r   <= 1'b0;
            brk_pend_r   <= 1'b0;
            ovf_d_r      <= 1'b0;
            nextdata_r   <= 1'b0;
            ev_valid_r   <= 1'b0;
            ev_code_r    <= 8'h00;
            ev_ext_r     <= 1'b0;
            ev_break_r   <= 1'b0;
            ev_repeat_r  <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else begin
            nextdata_r <= 1'b0;
            ovf_d_r    <= bus.kb_overflow;
            if (ovf_rise_s) begin
                ovf_sticky_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.kb_ready) begin
                        byte_r     <= bus.kb_data;
                        nextdata_r <= 1'b1;
                        state_r    <= DECODE;
                    end
                end
                DECODE: begin
                    if (byte_r == SC_EXT) begin
                        ext_pend_r <= 1'b1;
                        state_r    <= IDLE;
                    end else if (byte_r == SC_BRK) begin
                        brk_pend_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        ext_pend_r <= 1'b0;
                        brk_pend_r <= 1'b0;
                        if (drop_s) begin
                            state_r <= IDLE;
                        end else begin
                            ev_valid_r  <= 1'b1;
                            ev_code_r   <= byte_r;
                            ev_ext_r    <= ext_pend_r;
                            ev_break_r  <= brk_pend_r;
                            ev_repeat_r <= is_repeat_s;
                            state_r     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.ev_ready) begin
                        ev_valid_r <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // The stream may be desynchronised after an overflow, so any
            // half-received prefix is discarded; this wins over a set above.
            if (ovf_rise_s) begin
                ext_pend_r <= 1'b0;
                brk_pend_r <= 1'b0;
            end
        end
    end

    assign bus.kb_nextdata     = nextdata_r;
    assign bus.ev_valid        = ev_valid_r;
    assign bus.ev_code         = ev_code_r;
    assign bus.ev_ext          = ev_ext_r;
    assign bus.ev_break        = ev_break_r;
    assign bus.ev_repeat       = ev_repeat_r;
    assign bus.overflow_sticky = ovf_sticky_r;

endmodule

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
- Sequencer between the PS/2 receive FIFO (ps2_keyboard: data/ready/nextdata/overflow) and downstream consumers (ASCII lookup, text terminal).
- Owns the FIFO read handshake, parses the scancode stream (E0 extended prefix, F0 break prefix), tracks modifier and caps-lock state, detects typematic repeat.
- Presents one key event at a time on a valid/ready interface.

Parameters:
- SUPPRESS_REPEAT, 1, 1 = drop typematic repeat makes; 0 = emit them with ev_repeat=1.
- CNT_W, 8, width of the press counter.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- kb_data  in  8  FIFO head byte; valid while kb_ready=1.
- kb_ready  in  1  FIFO non-empty.
- kb_overflow  in  1  FIFO overflow flag.
- kb_nextdata  out  1  one-cycle pop strobe to the FIFO.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_code  out  8  scancode of the event (prefixes stripped).
- ev_ext  out  1  event was E0-prefixed.
- ev_break  out  1  1 = release, 0 = press.
- ev_repeat  out  1  make of a key that is already held.
- shift  out  1  left (12) or right (59) shift held.
- ctrl  out  1  ctrl (14 or E0 14) held.
- caps  out  1  caps-lock toggle state.
- press_cnt  out  CNT_W  count of non-repeat makes.
- overflow_sticky  out  1  set on any kb_overflow; cleared only by reset.

Behaviour:
- Reset (clrn=0, asynchronous): all outputs 0; state IDLE; ext_pend, brk_pend, held_valid, held_code, held_ext cleared.
- States: IDLE, DECODE, EMIT.
- IDLE:
  - On an edge with kb_ready=1: latch kb_data into byte_r, register kb_nextdata=1 for exactly the next cycle, go to DECODE.
  - kb_nextdata is never high for two consecutive cycles, and never high outside the cycle after a latch.
- DECODE (one cycle):
  - byte E0: set ext_pend, go to IDLE.
  - byte F0: set brk_pend, go to IDLE.
  - Any other byte: form the event {code=byte_r, ext=ext_pend, break=brk_pend}, clear both pend flags, update state as below, then go to EMIT. If the event is a suppressed repeat, go to IDLE instead.
- State update per event:
  - Make of 12/59 sets shift; break of either clears it. Shift is one shared bit: releasing one shift key clears it even if the other is still held.
  - Make of 14 (either ext) sets ctrl; break clears it.
  - Non-repeat make of 58 (non-ext) toggles caps.
  - Repeat = make with held_valid=1 and {held_code, held_ext} equal to the event.
  - Non-repeat make: held <= event; press_cnt += 1, wrapping 2^CNT_W-1 -> 0.
  - Break matching held: held_valid <= 0. Break of any other key leaves held unchanged.
- EMIT:
  - ev_valid=1 and all ev_* stable until the cycle with ev_ready=1.
  - Then ev_valid=0 on the next cycle and return to IDLE.
  - No FIFO pops while in EMIT (backpressure is held in the FIFO).
- Latency: kb_ready sampled at edge N -> kb_nextdata high in cycle N+1 -> ev_valid high from cycle N+2. Prefix bytes consume 2 cycles and produce no event.
- Overflow: a rising edge of kb_overflow sets overflow_sticky and clears ext_pend/brk_pend, because the stream may be desynchronised. Held key and modifiers are kept.
- Simultaneous cases:
  - Overflow rising during DECODE: the pend-flag clear takes priority over the pend-flag set.
  - ev_ready high while ev_valid=0 is ignored.
- Reset during EMIT or DECODE drops the in-flight event.

Decomposition:
- Shared package kbd_pkg:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58.
  - State encoding IDLE/DECODE/EMIT.
- One natural sub-module: kbd_mod_state. It takes a decoded event plus a strobe and holds shift/ctrl/caps/held-key/repeat logic and press_cnt. The top keeps the FSM and both handshakes.

Test Plan:
- FIFO bytes 1C, F0 1C, ev_ready tied 1 -> two events: {1C,make,cnt=1} then {1C,break}; kb_nextdata pulsed 3 times, each 1 cycle.
- Bytes 12, 1C, F0 1C, F0 12 -> shift=1 while A press/release emit, shift=0 after final break; press_cnt=2.
- Bytes 1C, 1C, 1C, F0 1C with SUPPRESS_REPEAT=1 -> exactly 2 events, press_cnt=1. With SUPPRESS_REPEAT=0 -> 4 events, the middle two with ev_repeat=1.
- Bytes E0 75, E0 F0 75 -> events {75,ext=1,make}, {75,ext=1,break}; 58, F0 58 -> caps toggles 0->1 once.
- ev_ready held 0 for 20 cycles with 3 bytes queued -> ev_valid and ev_code stable, kb_nextdata stays 0. Release -> remaining bytes drained in order.
- Feed F0, pulse kb_overflow, feed 1C -> overflow_sticky=1, event 1C reported as make. Assert clrn mid-EMIT -> all outputs 0 immediately.
